// File: rtl/conv_window_addr_gen_if.sv
// Read-address stream from the window address generator to the input-buffer read port.
// The master drives the beat; the slave returns ready.
interface conv_window_addr_gen_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  valid;
  logic                  ready;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  pad;
  logic                  last;

  modport master (output valid, addr, pad, last, input ready);
  modport slave  (input valid, addr, pad, last, output ready);
endinterface

// File: rtl/conv_window_addr_gen.sv
// Walks a KxK window over C channels for one output pixel and streams one input-buffer
// read address per beat, flagging zero-padding taps so the consumer injects zero.
module conv_window_addr_gen #(
  parameter int ADDR_WIDTH = 10,
  parameter int DIM_WIDTH  = 6,
  parameter int CH_WIDTH   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clear,
  input  logic                  i_start,
  input  logic [DIM_WIDTH-1:0]  i_k_size,
  input  logic [DIM_WIDTH-1:0]  i_i_size,
  input  logic [CH_WIDTH-1:0]   i_channels,
  input  logic [DIM_WIDTH-1:0]  i_stride,
  input  logic [DIM_WIDTH-1:0]  i_pad,
  input  logic [DIM_WIDTH-1:0]  i_o_row,
  input  logic [DIM_WIDTH-1:0]  i_o_col,
  input  logic [ADDR_WIDTH-1:0] i_start_addr,
  conv_window_addr_gen_if.master o_rd,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int SW = 2 * DIM_WIDTH + 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            r_state;
  logic [DIM_WIDTH-1:0]  r_k, r_n, r_s, r_p, r_orow, r_ocol;
  logic [CH_WIDTH-1:0]   r_ch;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [CH_WIDTH-1:0]   r_c;
  logic [DIM_WIDTH-1:0]  r_kr, r_kc;
  logic                  r_valid, r_pad, r_last, r_busy, r_done;
  logic [ADDR_WIDTH-1:0] r_addr;

  logic                  w_start_acc, w_xfer, w_load;
  logic [1:0]            w_state_nxt;
  logic [DIM_WIDTH-1:0]  w_k, w_n, w_s, w_p, w_orow, w_ocol;
  logic [CH_WIDTH-1:0]   w_ch;
  logic [ADDR_WIDTH-1:0] w_base;
  logic [CH_WIDTH-1:0]   w_nc;
  logic [DIM_WIDTH-1:0]  w_nkr, w_nkc;
  logic [SW-1:0]         w_row, w_col;
  logic                  w_pad, w_last;
  logic [ADDR_WIDTH-1:0] w_plane, w_addr_raw, w_addr;

  // Handshake qualifiers and the configuration source for the beat being prepared.
  always_comb begin
    w_start_acc = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    w_xfer      = (r_state == S_RUN) && r_valid && o_rd.ready;
    if (w_start_acc) begin
      w_k    = i_k_size;
      w_n    = i_i_size;
      w_ch   = i_channels;
      w_s    = (i_stride == DIM_WIDTH'(0)) ? DIM_WIDTH'(1) : i_stride;
      w_p    = i_pad;
      w_orow = i_o_row;
      w_ocol = i_o_col;
      w_base = i_start_addr;
    end else begin
      w_k    = r_k;
      w_n    = r_n;
      w_ch   = r_ch;
      w_s    = r_s;
      w_p    = r_p;
      w_orow = r_orow;
      w_ocol = r_ocol;
      w_base = r_base;
    end
  end

  // Window counters for the next beat: kc innermost, then kr, then channel.
  always_comb begin
    w_nc  = r_c;
    w_nkr = r_kr;
    w_nkc = r_kc;
    if (w_start_acc) begin
      w_nc  = CH_WIDTH'(0);
      w_nkr = DIM_WIDTH'(0);
      w_nkc = DIM_WIDTH'(0);
    end else if (r_kc == w_k - DIM_WIDTH'(1)) begin
      w_nkc = DIM_WIDTH'(0);
      if (r_kr == w_k - DIM_WIDTH'(1)) begin
        w_nkr = DIM_WIDTH'(0);
        w_nc  = r_c + CH_WIDTH'(1);
      end else begin
        w_nkr = r_kr + DIM_WIDTH'(1);
        w_nc  = r_c;
      end
    end else begin
      w_nkc = r_kc + DIM_WIDTH'(1);
      w_nkr = r_kr;
      w_nc  = r_c;
    end
  end

  // Tap position, padding test and buffer address; a negative coordinate sets the MSB.
  always_comb begin
    w_row      = SW'(w_orow) * SW'(w_s) + SW'(w_nkr) - SW'(w_p);
    w_col      = SW'(w_ocol) * SW'(w_s) + SW'(w_nkc) - SW'(w_p);
    w_pad      = w_row[SW-1] || w_col[SW-1] || (w_row >= SW'(w_n)) || (w_col >= SW'(w_n));
    w_plane    = ADDR_WIDTH'(w_n) * ADDR_WIDTH'(w_n);
    w_addr_raw = w_base + ADDR_WIDTH'(w_nc) * w_plane
               + ADDR_WIDTH'(w_row) * ADDR_WIDTH'(w_n) + ADDR_WIDTH'(w_col);
    if (w_pad) begin
      w_addr = {ADDR_WIDTH{1'b0}};
    end else begin
      w_addr = w_addr_raw;
    end
    w_last = (w_nc == w_ch - CH_WIDTH'(1)) && (w_nkr == w_k - DIM_WIDTH'(1))
          && (w_nkc == w_k - DIM_WIDTH'(1));
  end

  // Next state and whether a new beat is loaded into the output registers.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start_acc) begin
          if ((w_k == DIM_WIDTH'(0)) || (w_ch == CH_WIDTH'(0))) begin
            w_state_nxt = S_DONE;
            w_load      = 1'b0;
          end else begin
            w_state_nxt = S_RUN;
            w_load      = 1'b1;
          end
        end else begin
          w_state_nxt = r_state;
          w_load      = 1'b0;
        end
      end
      S_RUN: begin
        if (w_xfer && r_last) begin
          w_state_nxt = S_DONE;
          w_load      = 1'b0;
        end else begin
          w_state_nxt = S_RUN;
          w_load      = w_xfer;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_load      = 1'b0;
      end
    endcase
  end

  // State, latched configuration, counters and registered beat outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_state <= S_IDLE;
      r_k     <= DIM_WIDTH'(0);
      r_n     <= DIM_WIDTH'(0);
      r_s     <= DIM_WIDTH'(0);
      r_p     <= DIM_WIDTH'(0);
      r_orow  <= DIM_WIDTH'(0);
      r_ocol  <= DIM_WIDTH'(0);
      r_ch    <= CH_WIDTH'(0);
      r_base  <= ADDR_WIDTH'(0);
      r_c     <= CH_WIDTH'(0);
      r_kr    <= DIM_WIDTH'(0);
      r_kc    <= DIM_WIDTH'(0);
      r_valid <= 1'b0;
      r_addr  <= ADDR_WIDTH'(0);
      r_pad   <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_acc) begin
        r_k    <= w_k;
        r_n    <= w_n;
        r_s    <= w_s;
        r_p    <= w_p;
        r_orow <= w_orow;
        r_ocol <= w_ocol;
        r_ch   <= w_ch;
        r_base <= w_base;
      end
      if (w_start_acc || w_load) begin
        r_c  <= w_nc;
        r_kr <= w_nkr;
        r_kc <= w_nkc;
      end
      if (w_load) begin
        r_addr <= w_addr;
        r_pad  <= w_pad;
        r_last <= w_last;
      end else if (w_state_nxt != S_RUN) begin
        r_addr <= ADDR_WIDTH'(0);
        r_pad  <= 1'b0;
        r_last <= 1'b0;
      end
      r_valid <= (w_state_nxt == S_RUN);
      r_busy  <= (w_state_nxt == S_RUN);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  assign o_rd.valid = r_valid;
  assign o_rd.addr  = r_addr;
  assign o_rd.pad   = r_pad;
  assign o_rd.last  = r_last;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule
